// File: rtl/reg_bank.sv
// reg_bank: DEPTH x WIDTH register file on a tri-state bus, with inc/dec counting and wrap flag.
// Optional macro REG_BANK_BYPASS_EN enables same-cycle write-through onto the read bus.

module reg_bank_cell #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             cnt,
    input  logic             up,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)  q <= '0;
        else if (clr)  q <= '0;
        else if (load) q <= load_val;
        else if (cnt)  q <= up ? q + WIDTH'(1) : q - WIDTH'(1);
    end
endmodule

module reg_bank #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             write,
    input  logic [AW-1:0]    wsel,
    input  logic [WIDTH-1:0] in,
    input  logic             enable,
    input  logic [AW-1:0]    rsel,
    output logic [WIDTH-1:0] out,
    input  logic             inc,
    input  logic             dec,
    input  logic [AW-1:0]    csel,
    output logic             wrap
);
    logic [DEPTH-1:0][WIDTH-1:0] regs;
    logic [WIDTH-1:0]            cur;
    logic [WIDTH-1:0]            rdata;
    logic                        csel_hit;
    logic                        cnt_go;
    logic                        wrap_next;

    // A write to the counter's own register wins; inc+dec together cancel.
    assign cnt_go = (inc ^ dec) && !(write && wsel == csel);

    for (genvar g = 0; g < DEPTH; g++) begin : g_cell
        reg_bank_cell #(.WIDTH(WIDTH)) u_cell (
            .clk      (clk),
            .reset_n  (reset_n),
            .clr      (clr),
            .load     (write && wsel == AW'(g)),
            .load_val (in),
            .cnt      (cnt_go && csel == AW'(g)),
            .up       (inc),
            .q        (regs[g])
        );
    end

    always_comb begin
        cur      = '0;
        csel_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (csel == AW'(i)) begin
                cur      = regs[i];
                csel_hit = 1'b1;
            end
        end
        wrap_next = cnt_go && csel_hit && (inc ? (&cur) : (~|cur));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) wrap <= 1'b0;
        else if (clr) wrap <= 1'b0;
        else          wrap <= wrap_next;
    end

    // Out-of-range selectors fall through the loop and read as zero.
    always_comb begin
        rdata = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rsel == AW'(i)) begin
`ifdef REG_BANK_BYPASS_EN
                rdata = (write && wsel == rsel) ? in : regs[i];
`else
                rdata = regs[i];
`endif
            end
        end
    end

    assign out = enable ? rdata : {WIDTH{1'bz}};
endmodule

// File: tb/tb_reg_bank.sv
// Directed, table-driven bench for reg_bank; a DEPTH=3 instance covers out-of-range selects.

module tb_reg_bank;
    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       clr = 1'b0, write = 1'b0, enable = 1'b0, inc = 1'b0, dec = 1'b0;
    logic [1:0] wsel = '0, rsel = '0, csel = '0;
    logic [7:0] din = '0;
    wire  [7:0] out, out3;
    logic       wrap, wrap3;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    reg_bank #(.WIDTH(8), .DEPTH(4)) dut (
        .clk(clk), .reset_n(reset_n), .clr(clr), .write(write), .wsel(wsel),
        .in(din), .enable(enable), .rsel(rsel), .out(out),
        .inc(inc), .dec(dec), .csel(csel), .wrap(wrap)
    );

    reg_bank #(.WIDTH(8), .DEPTH(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .clr(clr), .write(write), .wsel(wsel),
        .in(din), .enable(enable), .rsel(rsel), .out(out3),
        .inc(inc), .dec(dec), .csel(csel), .wrap(wrap3)
    );

    typedef struct {
        logic       wr;
        logic [1:0] wsel;
        logic [7:0] din;
        logic       inc;
        logic       dec;
        logic [1:0] csel;
        logic [1:0] rsel;
        logic [7:0] exp_out;
        logic       exp_wrap;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic wr, logic [1:0] ws, logic [7:0] d, logic i, logic dc,
                                logic [1:0] cs, logic [1:0] rs, logic [7:0] eo, logic ew);
        vec_t v;
        v.wr = wr; v.wsel = ws; v.din = d; v.inc = i; v.dec = dc;
        v.csel = cs; v.rsel = rs; v.exp_out = eo; v.exp_wrap = ew;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle();
        write = 1'b0; inc = 1'b0; dec = 1'b0; clr = 1'b0;
    endtask

    task automatic wr_reg(input logic [1:0] r, input logic [7:0] d);
        @(negedge clk);
        write = 1'b1; wsel = r; din = d;
        @(posedge clk); #1;
        idle();
    endtask

    initial begin
        // Async reset takes effect without a clock; bus driver follows enable.
        enable = 1'b1; rsel = 2'd2;
        #1 reset_n = 1'b0;
        #1 chk("reset_out", out, 8'h00);
        chk("reset_wrap", {7'b0, wrap}, 8'h00);
        enable = 1'b0;
        #1 checks++;
        if (out !== 8'hzz) begin
            failures++;
            $display("FAIL reset_z: got %h expected zz", out);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;

        //               wr ws  din   inc dec cs  rs  out   wrap
        vecs.push_back(mk(1, 1, 8'h5A, 0, 0, 0, 1, 8'h5A, 0));
        vecs.push_back(mk(1, 0, 8'h11, 0, 0, 0, 0, 8'h11, 0));
        vecs.push_back(mk(1, 1, 8'h22, 0, 0, 0, 1, 8'h22, 0));
        vecs.push_back(mk(1, 2, 8'h33, 0, 0, 0, 2, 8'h33, 0));
        vecs.push_back(mk(1, 3, 8'h44, 0, 0, 0, 3, 8'h44, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 8'h11, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0, 1, 8'h22, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0, 2, 8'h33, 0));
        vecs.push_back(mk(1, 3, 8'hFE, 0, 0, 0, 3, 8'hFE, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, 3, 3, 8'hFF, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, 3, 3, 8'h00, 1));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 3, 3, 8'h00, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 1, 3, 3, 8'hFF, 1));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 3, 3, 8'hFF, 0));
        vecs.push_back(mk(1, 2, 8'h80, 1, 0, 2, 2, 8'h80, 0));
        vecs.push_back(mk(1, 1, 8'h07, 0, 0, 0, 1, 8'h07, 0));
        vecs.push_back(mk(1, 0, 8'h10, 1, 0, 1, 1, 8'h08, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 8'h10, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 1, 1, 1, 8'h08, 0));
        vecs.push_back(mk(1, 2, 8'hFF, 0, 0, 0, 2, 8'hFF, 0));
        vecs.push_back(mk(1, 2, 8'h01, 1, 0, 2, 2, 8'h01, 0));
        vecs.push_back(mk(1, 0, 8'hAB, 1, 0, 3, 3, 8'h00, 1));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 8'hAB, 0));

        foreach (vecs[k]) begin
            @(negedge clk);
            write = vecs[k].wr; wsel = vecs[k].wsel; din = vecs[k].din;
            inc = vecs[k].inc; dec = vecs[k].dec; csel = vecs[k].csel;
            enable = 1'b1; rsel = vecs[k].rsel;
            @(posedge clk); #1;
            idle();
            #1;
            chk($sformatf("vec%0d_out", k), out, vecs[k].exp_out);
            chk($sformatf("vec%0d_wrap", k), {7'b0, wrap}, {7'b0, vecs[k].exp_wrap});
        end

        // Bus released mid-operation.
        enable = 1'b0;
        #1 checks++;
        if (out !== 8'hzz) begin
            failures++;
            $display("FAIL run_z: got %h expected zz", out);
        end

        // Out-of-range select on the DEPTH=3 instance: write/count on sel 3 ignored, read 0.
        wr_reg(2'd3, 8'hFF);
        @(negedge clk);
        inc = 1'b1; csel = 2'd3;
        @(posedge clk); #1;
        idle();
        enable = 1'b1; rsel = 2'd3;
        #1 chk("oor_main_out", out, 8'h00);
        chk("oor_main_wrap", {7'b0, wrap}, 8'h01);
        chk("oor_d3_out", out3, 8'h00);
        chk("oor_d3_wrap", {7'b0, wrap3}, 8'h00);
        rsel = 2'd2;
        #1 chk("oor_d3_r2", out3, 8'h01);

        // Synchronous clear.
        for (int r = 0; r < 4; r++) wr_reg(2'(r), 8'(8'h21 + r));
        @(negedge clk) clr = 1'b1;
        @(posedge clk); #1;
        idle();
        for (int r = 0; r < 4; r++) begin
            rsel = 2'(r);
            #1 chk($sformatf("clr_r%0d", r), out, 8'h00);
        end

        // Async reset between edges clears before the next edge.
        for (int r = 0; r < 4; r++) wr_reg(2'(r), 8'(8'h91 + r));
        @(negedge clk);
        rsel = 2'd0;
        #1 chk("preload_r0", out, 8'h91);
        reset_n = 1'b0;
        for (int r = 0; r < 4; r++) begin
            rsel = 2'(r);
            #0.5 chk($sformatf("arst_r%0d", r), out, 8'h00);
        end
        @(negedge clk) reset_n = 1'b1;

        // Write-through bypass on r1 (holds 0 after reset).
        @(negedge clk);
        write = 1'b1; din = 8'hC3; wsel = 2'd1; rsel = 2'd1; enable = 1'b1;
        #1;
`ifdef REG_BANK_BYPASS_EN
        chk("bypass_pre", out, 8'hC3);
`else
        chk("bypass_pre", out, 8'h00);
`endif
        @(posedge clk); #1;
        chk("bypass_post", out, 8'hC3);
        idle();
        #1 chk("bypass_stored", out, 8'hC3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/reg_bank.md
# reg_bank

Parametrised bank of DEPTH registers, each WIDTH bits wide, on the shared tri-state data bus of the 8-bit CPU. It serves as the general-purpose register file and as counter registers (program counter and stack pointer). It has one bus write port, one bus read port with a tri-state driver, and an increment/decrement path on a separately selected register with wrap detection.

## Interface
- WIDTH, 8, bit width of each register and of the bus.
- DEPTH, 4, number of registers; must be ≥2. Selector width AW = $clog2(DEPTH).
- clk  input  1  clock; all state changes on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- clr  input  1  synchronous clear of all registers.
- write  input  1  write `in` into register `wsel` at the next rising edge.
- wsel  input  AW  write register select.
- in  input  WIDTH  write data.
- enable  input  1  drive `out` with register `rsel`; otherwise `out` is high-impedance.
- rsel  input  AW  read register select.
- out  output  WIDTH  tri-state bus output.
- inc  input  1  increment register `csel` by 1.
- dec  input  1  decrement register `csel` by 1.
- csel  input  AW  counter register select.
- wrap  output  1  registered; high for one cycle after an inc or dec wrapped.

## Operation
- Storage: DEPTH × WIDTH flops plus the `wrap` flop.
- Priority at each rising edge, highest first:
  - `clr`: all registers ← 0, `wrap` ← 0.
  - `write`: register[wsel] ← in.
  - Counting: inc/dec on register[csel].
- Counting rules:
  - If `write` is high and wsel == csel, the write wins and the inc/dec is dropped; `wrap` ← 0.
  - If wsel ≠ csel, the write and the count both take effect in the same edge.
  - `inc` and `dec` both high: no-op, `wrap` ← 0.
  - Count arithmetic is modulo 2^WIDTH.
- Wrap:
  - inc from all-ones gives 0 and sets `wrap` ← 1.
  - dec from 0 gives all-ones and sets `wrap` ← 1.
  - Any other edge sets `wrap` ← 0.
- Select range: a selector value ≥ DEPTH is ignored for write and count (no state change); a read of such a value drives 0 when `enable` is high.
- Read: `out` = enable ? register[rsel] : all-Z. The read path is purely combinational from stored state.

## Timing
- Reset: while `reset_n` is low, all registers = 0 and `wrap` = 0, taking effect immediately without waiting for a clock. `out` still follows `enable` (drives 0 or Z).
- Reset mid-operation: a write or count pending in the same cycle is lost. The first edge after `reset_n` rises operates normally.
- Write latency: 1 cycle. A value written at edge N is visible on `out` right after edge N.
- Count latency: 1 cycle. `wrap` is valid during the cycle following the wrapping edge.
- No handshake: every request is accepted in the cycle it is presented. Holding `inc` high counts once per cycle.
- `out` changes combinationally with `enable`, `rsel`, and register contents. No clock is needed to turn the bus driver on or off.

## Configuration
- Macro REG_BANK_BYPASS_EN.
- Defined:
  - When `write` is high, enable is high, and rsel == wsel (in range), `out` = `in` combinationally in the same cycle (write-through).
  - Counting results are never bypassed.
- Undefined:
  - `out` always shows stored contents, i.e. the old value until the edge.
- Reset and all other behaviour are identical in both builds.

## Test plan
- Reset and bus release: reset_n=0 with enable=1, rsel=2 → out=0x00. enable=0 → out=ZZ. Release reset, write 0x5A to r1 → r1=0x5A after one edge.
- Write/read all: write 0x11, 0x22, 0x33, 0x44 into r0–r3 on successive edges, then read each → exact values. enable=0 → Z.
- Counter wrap: write r3=0xFE, then inc for 2 cycles → r3=0xFF (wrap=0), then 0x00 with wrap=1 for exactly one cycle. Then dec once → 0xFF with wrap=1.
- Collisions:
  - write r2=0x80 with inc, csel=2 → r2=0x80, wrap=0.
  - write r0=0x10 with inc, csel=1, r1=0x07 → r0=0x10, r1=0x08.
  - inc and dec together → unchanged.
- Clear vs async reset: load r0–r3 non-zero, clr=1 for one edge → all 0. Load again, pull reset_n low between edges → all 0 before the next edge.
- Bypass: write=1, in=0xC3, wsel=rsel=1, enable=1, old r1=0x00 → out=0xC3 pre-edge with REG_BANK_BYPASS_EN, 0x00 without. Both builds show 0xC3 post-edge.
